// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer: owns the PC, selects next PC, fills the IF/ID register.
// Optional misaligned-redirect fault enabled by defining IFETCH_ALIGN_CHECK_EN.
module ifetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] im_addr,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [31:0] IM_LIMIT = 32'(IM_BYTES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4_s;
    logic [31:0] br_target_s;
    logic [31:0] jmp_target_s;
    logic [31:0] jr_target_s;
    logic [31:0] redir_target_s;
    logic        redirect_s;
    logic        misalign_s;
    logic        out_of_range_s;

    function automatic logic [31:0] sel_target(
        input logic        f_jr,
        input logic        f_jump,
        input logic [31:0] t_jr,
        input logic [31:0] t_jump,
        input logic [31:0] t_br
    );
        logic [31:0] t;
        if (f_jr) begin
            t = t_jr;
        end else if (f_jump) begin
            t = t_jump;
        end else begin
            t = t_br;
        end
        return t;
    endfunction

    // Candidate redirect targets and range/alignment qualifiers on the current pc
    always_comb begin
        pc_plus4_s     = pc_q + 32'd4;
        br_target_s    = pc_plus4_s + {{14{br_offset[15]}}, br_offset, 2'b00};
        jmp_target_s   = {pc_plus4_s[31:28], jump_target, 2'b00};
`ifdef IFETCH_ALIGN_CHECK_EN
        jr_target_s    = jr_addr;
`else
        jr_target_s    = jr_addr & 32'hFFFF_FFFC;
`endif
        redirect_s     = jr | jump | br_taken;
        redir_target_s = sel_target(jr, jump, jr_target_s, jmp_target_s, br_target_s);
`ifdef IFETCH_ALIGN_CHECK_EN
        misalign_s     = (redir_target_s[1:0] != 2'b00);
`else
        misalign_s     = 1'b0;
`endif
        out_of_range_s = (pc_q >= IM_LIMIT);
    end

    // Next-state, next-PC and IF/ID selection
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        fault_d      = fault_q;
        case (state_q)
            S_BOOT: begin
                ifid_valid_d = 1'b0;
                state_d      = S_RUN;
            end
            S_RUN: begin
                // Range fault outranks redirects and stall; the word is dropped.
                if (out_of_range_s || (redirect_s && misalign_s)) begin
                    fault_d      = 1'b1;
                    ifid_valid_d = 1'b0;
                    state_d      = S_HALT;
                end else if (redirect_s) begin
                    pc_d         = redir_target_s;
                    ifid_instr_d = 32'h0000_0000;
                    ifid_valid_d = 1'b0;
                    state_d      = S_FLUSH;
                end else if (stall) begin
                    pc_d         = pc_q;
                    ifid_valid_d = ifid_valid_q;
                end else begin
                    pc_d         = pc_plus4_s;
                    ifid_instr_d = im_instr;
                    ifid_pc4_d   = pc_plus4_s;
                    ifid_valid_d = 1'b1;
                end
            end
            S_FLUSH: begin
                // pc holds here so the redirect target is fetched on the next RUN cycle.
                if (out_of_range_s) begin
                    fault_d      = 1'b1;
                    ifid_valid_d = 1'b0;
                    state_d      = S_HALT;
                end else begin
                    ifid_instr_d = 32'h0000_0000;
                    ifid_valid_d = 1'b0;
                    state_d      = S_RUN;
                end
            end
            S_HALT: begin
                ifid_valid_d = 1'b0;
                state_d      = S_HALT;
            end
            default: begin
                fault_d      = 1'b1;
                ifid_valid_d = 1'b0;
                state_d      = S_HALT;
            end
        endcase
    end

    // State, PC and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign im_addr    = pc_q;
    assign pc         = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq: IM word n holds value n; expected values are hand-computed.
module tb_ifetch_seq;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] im_instr;
    logic [31:0] im_addr;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fault;

    logic [31:0] mem [0:1023];
    int checks;
    int errors;

    ifetch_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jump        (jump),
        .jump_target (jump_target),
        .jr          (jr),
        .jr_addr     (jr_addr),
        .im_instr    (im_instr),
        .im_addr     (im_addr),
        .pc          (pc),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid),
        .fault       (fault)
    );

    assign im_instr = mem[im_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        stall = 1'b0; br_taken = 1'b0; br_offset = 16'h0000;
        jump = 1'b0; jump_target = 26'h0; jr = 1'b0; jr_addr = 32'h0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc4", ifid_pc4, 32'h0);
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        tick();
        chk("boot_pc", pc, 32'h0);
        chk("boot_valid", 32'(ifid_valid), 32'h0);
        tick();
        chk("seq0_pc", pc, 32'h4);
        chk("seq0_instr", ifid_instr, 32'h0);
        chk("seq0_pc4", ifid_pc4, 32'h4);
        chk("seq0_valid", 32'(ifid_valid), 32'h1);
        tick();
        chk("seq1_instr", ifid_instr, 32'h1);
        chk("seq1_pc4", ifid_pc4, 32'h8);
        tick();
        chk("seq2_instr", ifid_instr, 32'h2);
        chk("seq2_pc4", ifid_pc4, 32'hC);
        tick();
        chk("pre_stall_pc", pc, 32'h10);

        stall = 1'b1;
        tick();
        chk("stall1_pc", pc, 32'h10);
        chk("stall1_instr", ifid_instr, 32'h3);
        tick();
        chk("stall2_pc", pc, 32'h10);
        chk("stall2_pc4", ifid_pc4, 32'h10);
        chk("stall2_valid", 32'(ifid_valid), 32'h1);
        stall = 1'b0;
        tick();
        chk("resume_pc", pc, 32'h14);
        chk("resume_instr", ifid_instr, 32'h4);

        for (int i = 0; i < 3; i++) tick();
        chk("pre_br_pc", pc, 32'h20);
        br_taken = 1'b1; br_offset = 16'hFFFC;
        tick();
        br_taken = 1'b0; br_offset = 16'h0000;
        chk("br_pc", pc, 32'h14);
        chk("br_valid", 32'(ifid_valid), 32'h0);
        chk("br_instr", ifid_instr, 32'h0);
        tick();
        chk("br_flush_pc", pc, 32'h14);
        chk("br_flush_valid", 32'(ifid_valid), 32'h0);
        tick();
        chk("br_fetch_pc", pc, 32'h18);
        chk("br_fetch_instr", ifid_instr, 32'h5);
        chk("br_fetch_valid", 32'(ifid_valid), 32'h1);

        for (int i = 0; i < 6; i++) tick();
        chk("pre_jr_pc", pc, 32'h30);
        jump = 1'b1; jump_target = 26'h40; jr = 1'b1; jr_addr = 32'h100; stall = 1'b1;
        tick();
        jump = 1'b0; jr = 1'b0; stall = 1'b0;
        chk("jr_wins_pc", pc, 32'h100);
        chk("jr_wins_valid", 32'(ifid_valid), 32'h0);
        tick();
        tick();
        chk("jr_fetch_pc", pc, 32'h104);
        chk("jr_fetch_instr", ifid_instr, 32'h40);

        jump = 1'b1; jump_target = 26'h40;
        tick();
        jump = 1'b0;
        chk("jump_pc", pc, 32'h100);
        chk("jump_valid", 32'(ifid_valid), 32'h0);
        tick();
        tick();
        chk("jump_fetch_pc", pc, 32'h104);

        for (int i = 0; i < 958; i++) tick();
        chk("run_ffc_pc", pc, 32'hFFC);
        chk("run_ffc_instr", ifid_instr, 32'h3FE);
        tick();
        chk("edge_pc", pc, 32'h1000);
        chk("edge_instr", ifid_instr, 32'h3FF);
        chk("edge_pc4", ifid_pc4, 32'h1000);
        chk("edge_fault", 32'(fault), 32'h0);
        tick();
        chk("oor_fault", 32'(fault), 32'h1);
        chk("oor_pc", pc, 32'h1000);
        chk("oor_valid", 32'(ifid_valid), 32'h0);
        jr = 1'b1; jr_addr = 32'h200;
        tick();
        jr = 1'b0;
        chk("halt_pc", pc, 32'h1000);
        chk("halt_fault", 32'(fault), 32'h1);

        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_fault", 32'(fault), 32'h0);
        chk("mid_rst_instr", ifid_instr, 32'h0);
        chk("mid_rst_pc4", ifid_pc4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("boot2_pc", pc, 32'h0);
        tick();
        chk("run2_pc", pc, 32'h4);
        jr = 1'b1; jr_addr = 32'h102;
        tick();
        jr = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("align_fault", 32'(fault), 32'h1);
        chk("align_pc", pc, 32'h4);
        chk("align_valid", 32'(ifid_valid), 32'h0);
        tick();
        chk("align_halt_pc", pc, 32'h4);
`else
        chk("jr_mask_pc", pc, 32'h100);
        chk("jr_mask_fault", 32'(fault), 32'h0);
        chk("jr_mask_valid", 32'(ifid_valid), 32'h0);
        tick();
        tick();
        chk("jr_mask_fetch", ifid_instr, 32'h40);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
